// File: rtl/mac_accum_block.sv
// Packet accumulator behind the product combiner, with a valid/ready result hold.
// Optional clamp-on-overflow when MAC_ACC_SAT_EN is defined (default: modulo wrap).
`timescale 1ns/1ps
module mac_accum_block #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5*MAC_MIN_WIDTH,
  parameter int MAC_ACC_WIDTH  = 6*MAC_MIN_WIDTH,
  parameter int MAC_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_INT_WIDTH-1:0]  in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_ACC_WIDTH-1:0]  out_data,
  output logic [MAC_CNT_WIDTH-1:0]  out_count,
  output logic                      out_ovf
);

  localparam int AW = MAC_ACC_WIDTH;
  localparam int IW = MAC_INT_WIDTH;
  localparam int CW = MAC_CNT_WIDTH;
  localparam int XW = AW - IW;

  localparam logic [MAC_CONF_WIDTH-1:0] CFG_QUAD = 2'b10;
  localparam logic [MAC_CONF_WIDTH-1:0] CFG_RSV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_HOLD  = 2'b10
  } state_e;

  state_e                    state_q;
  logic [MAC_CONF_WIDTH-1:0] cfg_q;
  logic [AW-1:0]             acc_q;
  logic [CW-1:0]             count_q;
  logic                      ovf_q;
  logic                      out_valid_q;
  logic [AW-1:0]             out_data_q;
  logic [CW-1:0]             out_count_q;
  logic                      out_ovf_q;

  logic                      accept;
  logic                      first;
  logic [MAC_CONF_WIDTH-1:0] cfg_eff;
  logic                      is_quad;
  logic                      is_rsv;
  logic [AW-1:0]             ext;
  logic [AW-1:0]             base;
  logic [AW:0]               sum_w;
  logic [AW-1:0]             sum;
  logic                      carry;
  logic                      sovf;
  logic                      ovf_now;
  logic [AW-1:0]             acc_d;
  logic [CW-1:0]             count_d;
  logic                      ovf_d;

  assign in_ready = en & (state_q != S_HOLD);
  assign accept   = in_valid & in_ready;
  assign first    = (state_q == S_IDLE);

  // First beat uses the live cfg; later beats use the latched copy.
  assign cfg_eff = first ? cfg : cfg_q;
  assign is_quad = (cfg_eff == CFG_QUAD);
  assign is_rsv  = (cfg_eff == CFG_RSV);

  always_comb begin
    ext = '0;
    if (!is_rsv) begin
      ext = {{XW{in_data[IW-1] & is_quad}}, in_data};
    end
  end

  assign base  = first ? '0 : acc_q;
  assign sum_w = {1'b0, base} + {1'b0, ext};
  assign sum   = sum_w[AW-1:0];
  assign carry = sum_w[AW];

  assign sovf = (base[AW-1] == ext[AW-1]) &
                (sum[AW-1] != base[AW-1]);

  always_comb begin
    ovf_now = 1'b0;
    if (!is_rsv) begin
      ovf_now = is_quad ? sovf : carry;
    end
  end

`ifdef MAC_ACC_SAT_EN
  logic [AW-1:0] clamp;

  always_comb begin
    clamp = '1;
    if (is_quad) begin
      clamp = base[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                         : {1'b0, {(AW-1){1'b1}}};
    end
  end

  assign acc_d = ovf_now ? clamp : sum;
`else
  assign acc_d = sum;
`endif

  always_comb begin
    count_d = CW'(1);
    if (!first) begin
      count_d = (count_q == '1) ? count_q : count_q + CW'(1);
    end
  end

  assign ovf_d = (first ? 1'b0 : ovf_q) | ovf_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (first) begin
              cfg_q <= cfg;
            end
            if (in_last) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
              out_count_q <= count_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accum_block.sv
// Directed bench for mac_accum_block: packets, signed quad, overflow,
// backpressure, stall with cfg change, reserved cfg and mid-packet reset.
`timescale 1ns/1ps
module tb_mac_accum_block;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  cfg;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  mac_accum_block dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("take_valid", 48'(out_valid), 48'd0);
    chk("take_ready", 48'(in_ready), 48'd1);
  endtask

  task automatic result(input string tag, input logic [47:0] d,
                        input logic [7:0] c, input logic o);
    chk({tag, "_valid"}, 48'(out_valid), 48'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_count"}, 48'(c), 48'(out_count));
    chk({tag, "_ovf"}, 48'(out_ovf), 48'(o));
  endtask

  logic [47:0] exp_sq;
  logic [47:0] exp_su;

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    cfg       = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 48'(out_valid), 48'd0);
    chk("rst_data", out_data, 48'd0);
    chk("rst_count", 48'(out_count), 48'd0);
    chk("rst_ovf", 48'(out_ovf), 48'd0);
    rst = 1'b1;
    tick();
    chk("idle_ready", 48'(in_ready), 48'd1);

    // single: 3 x 0xFE01
    cfg = 2'b00;
    send(40'h00_0000_FE01, 1'b0);
    send(40'h00_0000_FE01, 1'b0);
    chk("acc_novalid", 48'(out_valid), 48'd0);
    send(40'h00_0000_FE01, 1'b1);
    result("single", 48'h2_FA03, 8'd3, 1'b0);
    chk("hold_ready", 48'(in_ready), 48'd0);
    take();

    // quad signed: -1 + 5
    cfg = 2'b10;
    send(40'hFF_FFFF_FFFF, 1'b0);
    send(40'h00_0000_0005, 1'b1);
    result("quad", 48'h4, 8'd2, 1'b0);

    // backpressure with a beat offered during hold
    in_valid = 1'b1;
    in_data  = 40'h00_0000_0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 48'(out_valid), 48'd1);
      chk("bp_data", out_data, 48'h4);
      chk("bp_ready", 48'(in_ready), 48'd0);
    end
    in_valid = 1'b0;
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("en0_hold", 48'(out_valid), 48'd1);
    en = 1'b1;
    out_ready = 1'b0;
    take();

    // quad overflow: 257 beats of 2^39-1
    exp_sq = 48'h807F_FFFF_FEFF;
    exp_su = 48'h00FF_FFFF_FEFF;
`ifdef MAC_ACC_SAT_EN
    exp_sq = 48'h7FFF_FFFF_FFFF;
    exp_su = 48'hFFFF_FFFF_FFFF;
`endif
    cfg = 2'b10;
    for (int i = 0; i < 257; i++) begin
      send(40'h7F_FFFF_FFFF, (i == 256));
    end
    result("qovf", exp_sq, 8'd255, 1'b1);
    take();

    // unsigned overflow: 257 beats of 2^40-1
    cfg = 2'b00;
    for (int i = 0; i < 257; i++) begin
      send(40'hFF_FFFF_FFFF, (i == 256));
    end
    result("uovf", exp_su, 8'd255, 1'b1);
    take();

    // single-beat packet, ovf cleared, dual zero-extend
    cfg = 2'b01;
    send(40'h92_3456_789A, 1'b1);
    result("one", 48'h0092_3456_789A, 8'd1, 1'b0);
    take();

    // reserved cfg contributes zero
    cfg = 2'b11;
    send(40'h00_0000_0005, 1'b0);
    send(40'h00_0000_0007, 1'b1);
    result("rsv", 48'h0, 8'd2, 1'b0);
    take();

    // stall with cfg change mid-packet
    cfg = 2'b10;
    send(40'hFF_FFFF_FFFE, 1'b0);
    en = 1'b0;
    cfg = 2'b00;
    in_valid = 1'b1;
    in_data = 40'h00_0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", 48'(in_ready), 48'd0);
      chk("stall_valid", 48'(out_valid), 48'd0);
    end
    in_valid = 1'b0;
    en = 1'b1;
    send(40'hFF_FFFF_FFFF, 1'b1);
    result("stall", 48'hFFFF_FFFF_FFFD, 8'd2, 1'b0);
    take();

    // reset mid-packet
    cfg = 2'b00;
    send(40'h00_0000_0010, 1'b0);
    send(40'h00_0000_0010, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst_valid", 48'(out_valid), 48'd0);
    chk("mrst_data", out_data, 48'd0);
    chk("mrst_count", 48'(out_count), 48'd0);
    tick();
    rst = 1'b1;
    tick();
    send(40'h00_0000_0003, 1'b1);
    result("post_rst", 48'h3, 8'd1, 1'b0);
    take();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
